// File: rtl/array_feeder_pkg.sv
// Shared definitions for the activation feeder and the PE array it drives.
package array_feeder_pkg;

   localparam int unsigned DEF_ARRAY_SIZE         = 4;
   localparam int unsigned DEF_COMPUTE_DATA_WIDTH = 4;
   localparam int unsigned DEF_BUFFER_WORD_SIZE   = 16;
   localparam int unsigned DEF_ADDR_WIDTH         = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/array_feeder_skew.sv
// Per-lane delay chain: DEPTH registers in series, cleared by reset.
module skew_delay
   import array_feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = DEF_COMPUTE_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;

   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din;
      for (int unsigned s = 1; s < DEPTH; s++) begin
         stage_d[s] = stage_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/array_feeder.sv
// Streams K activation words from the input buffer into a skewed systolic
// array front, then holds compute high while partial sums drain.
module array_feeder
   import array_feeder_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE         = DEF_ARRAY_SIZE,
   parameter int unsigned COMPUTE_DATA_WIDTH = DEF_COMPUTE_DATA_WIDTH,
   parameter int unsigned BUFFER_WORD_SIZE   = DEF_BUFFER_WORD_SIZE,
   parameter int unsigned ADDR_WIDTH         = DEF_ADDR_WIDTH
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           start,
   input  logic [ADDR_WIDTH-1:0]                          base_addr,
   input  logic [ADDR_WIDTH-1:0]                          num_vectors,
   output logic                                           rd_en,
   output logic [ADDR_WIDTH-1:0]                          rd_addr,
   input  logic [BUFFER_WORD_SIZE-1:0]                    rd_data,
   output logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0]  ins,
   output logic                                           compute,
   output logic                                           busy,
   output logic                                           done
);

   localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
   localparam int unsigned DRAIN_LEN = 2 * ARRAY_SIZE;

   if (BUFFER_WORD_SIZE != ARRAY_SIZE * COMPUTE_DATA_WIDTH) begin : g_width_check
      $error("array_feeder: BUFFER_WORD_SIZE must equal ARRAY_SIZE*COMPUTE_DATA_WIDTH");
   end

   feeder_state_e         state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  rd_en_q,   rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  compute_q, compute_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;

   // cnt holds remaining reads in FETCH, then remaining drain cycles in DRAIN
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_vectors != '0) begin
                  state_d   = FETCH;
                  cnt_d     = CNT_W'(num_vectors);
                  rd_addr_d = base_addr;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FETCH: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = DRAIN;
               cnt_d   = CNT_W'(DRAIN_LEN - 1);
            end else begin
               cnt_d     = cnt_q - CNT_W'(1);
               rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = FINISH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rd_en_d    = (state_d == FETCH);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == FINISH);
      rd_valid_d = rd_en_q;
      // compute opens once the first word lands and closes with the drain
      compute_d  = (rd_valid_q || compute_q) && ((state_d == FETCH) || (state_d == DRAIN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         rd_valid_q <= 1'b0;
         compute_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         rd_valid_q <= rd_valid_d;
         compute_q  <= compute_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Lanes are zeroed unless a requested word is on rd_data, so stale data never enters the skew
   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      logic [COMPUTE_DATA_WIDTH-1:0] lane_c;

      assign lane_c = rd_valid_q ? rd_data[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] : '0;

      skew_delay #(
         .DEPTH (i + 1),
         .WIDTH (COMPUTE_DATA_WIDTH)
      ) u_skew (
         .clk  (clk),
         .rst  (rst),
         .din  (lane_c),
         .dout (ins[i])
      );
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign compute = compute_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: doc/array_feeder.md
ARRAY_FEEDER -- requirements
Module: array_feeder

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 4: rows of the PE array fed, equal to the number of lanes per word.
REQ-002 SHALL have parameter COMPUTE_DATA_WIDTH, default 4: activation lane width.
REQ-003 SHALL have parameter BUFFER_WORD_SIZE, default 16: input buffer word width; elaboration SHALL fail unless BUFFER_WORD_SIZE == ARRAY_SIZE*COMPUTE_DATA_WIDTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: buffer address width and vector-count width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_WIDTH  address of the first activation word.
REQ-009 num_vectors  in  ADDR_WIDTH  K, number of words to stream; 0 is legal.
REQ-010 rd_en  out  1  buffer read strobe.
REQ-011 rd_addr  out  ADDR_WIDTH  buffer read address.
REQ-012 rd_data  in  BUFFER_WORD_SIZE  buffer data, valid exactly one cycle after rd_en.
REQ-013 ins  out  ARRAY_SIZE x COMPUTE_DATA_WIDTH  skewed per-row activations to the PE array.
REQ-014 compute  out  1  array compute enable.
REQ-015 busy  out  1  high from the cycle after an accepted start through the done cycle.
REQ-016 done  out  1  one-cycle pulse at the end of a run.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, FINISH; IDLE->FETCH on start with K>0; IDLE->FINISH on start with K==0; FETCH->DRAIN after K reads; DRAIN->FINISH after the last compute cycle; FINISH->IDLE unconditionally.
REQ-018 SHALL latch base_addr and num_vectors when start is accepted; later input changes SHALL not affect the run.
REQ-019 With start accepted at cycle c, SHALL assert rd_en for cycles c+1..c+K with rd_addr = base_addr+n at cycle c+1+n, incrementing modulo 2^ADDR_WIDTH (wrap-around).
REQ-020 SHALL unpack lane i of word n as rd_data[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH].
REQ-021 SHALL drive ins[i] = lane i of word n during cycle c+3+n+i through a register chain of depth i+1 per lane; ins[i] SHALL be zero in every other cycle.
REQ-022 SHALL drive compute high for exactly cycles c+3 .. c+2+K+2*(ARRAY_SIZE-1) (K+2*(ARRAY_SIZE-1) cycles, covering skew fill and partial-sum propagation).
REQ-023 SHALL pulse done for one cycle at c+3+K+2*(ARRAY_SIZE-1) when K>0, and at c+1 when K==0 (no rd_en, no compute).
REQ-024 SHALL ignore start while busy is high, including in the done cycle.
REQ-025 SHALL accept a new start in the cycle after done (back-to-back runs) with no gap cycles beyond REQ-019.
REQ-026 Down-counters SHALL be ADDR_WIDTH+1 bits so K = 2^ADDR_WIDTH-1 plus drain never overflows.

Reset
REQ-027 On rst SHALL enter IDLE; rd_en, rd_addr, ins (all lanes), compute, busy, done and all skew registers SHALL be zero the next cycle.
REQ-028 rst asserted mid-run SHALL abort the run with no done pulse; rd_data arriving after reset SHALL be discarded.
REQ-029 rst SHALL take priority over start in the same cycle.

Structure
REQ-030 The state enum and default parameter values SHALL live in the shared package used by the PE array.
REQ-031 The per-lane delay chain SHALL be one sub-module, skew_delay, parameterised by depth and width, instantiated ARRAY_SIZE times via generate.
REQ-032 RTL SHALL be 120-400 lines with no latches and no combinational path from rd_data to any output.

Verification
REQ-033 Reset: rst high for 2 cycles mid-run with K=5 -> all outputs 0 next cycle, no done, FSM in IDLE.
REQ-034 Single word: start c, base 0x10, K=1, rd_data 0x4321 at c+2 -> rd_en only at c+1 addr 0x10; ins[0]=1 @c+3, ins[1]=2 @c+4, ins[2]=3 @c+5, ins[3]=4 @c+6; compute c+3..c+9; done @c+10.
REQ-035 Stream K=3, words 0x1111,0x2222,0x3333 -> ins[3]=1,2,3 at c+6,c+7,c+8; compute 9 cycles c+3..c+11; done @c+12.
REQ-036 Wrap: base 0xFE, K=4 -> rd_addr 0xFE,0xFF,0x00,0x01.
REQ-037 K=0 -> done @c+1, busy only @c+1, no rd_en, no compute.
REQ-038 Start pulsed while busy, then again the cycle after done -> first ignored, second starts a run with rd_en two cycles after done.
